instr_cycle_ctrl: RTL

//  Top-level instruction-cycle FSM in front of the microcode sequencer.

---
 rtl/instr_cycle_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_cycle_ctrl
// Purpose  : Instruction-cycle FSM sitting in front of the microcode
//            sequencer. Fetches instruction words from IRAM, resolves
//            JMP / JMPZ / END locally and hands every other opcode to the
//            microsequencer through a go/op/done handshake. Advances the PC
//            on retirement, honours halt requests only at instruction
//            boundaries, and halts with an error if a micro-op never
//            completes (watchdog).
// Ports    : clk, rst          - clock (rising edge), synchronous reset (high)
//            start             - begin / restart execution (IDLE or HALT)
//            halt_req          - halt at the next instruction boundary
//            iram_rd_en/addr   - IRAM read strobe and address (= pc)
//            iram_rdata        - IRAM data, IRAM_LAT cycles after the strobe
//            z_flag            - ALU zero flag used by JMPZ
//            useq_go/op/done   - microsequencer dispatch handshake
//            pc, busy, halted  - architectural status
//            wdog_err          - sticky micro-op timeout flag
//            instr_count       - retired instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module instr_cycle_ctrl #(
    parameter int               OPW      = 6,
    parameter int               PCW      = 8,
    parameter int               IW       = 16,
    parameter int               IRAM_LAT = 1,
    parameter logic [OPW-1:0]   JMP_OP   = OPW'(57),
    parameter logic [OPW-1:0]   JMPZ_OP  = OPW'(58),
    parameter logic [OPW-1:0]   END_OP   = OPW'(59),
    parameter int               WDOG     = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt_req,
    output logic            iram_rd_en,
    output logic [PCW-1:0]  iram_addr,
    input  logic [IW-1:0]   iram_rdata,
    input  logic            z_flag,
    output logic            useq_go,
    output logic [OPW-1:0]  useq_op,
    input  logic            useq_done,
    output logic [PCW-1:0]  pc,
    output logic            busy,
    output logic            halted,
    output logic            wdog_err,
    output logic [15:0]     instr_count
);

    localparam int WDW = $clog2(WDOG + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT     = 3'd2,
        S_DECODE   = 3'd3,
        S_DISPATCH = 3'd4,
        S_EXEC     = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PCW-1:0]     r_pc;
    logic [IW-1:0]      r_ir;
    logic [OPW-1:0]     r_useq_op;
    logic [15:0]        r_count;
    logic               r_wdog_err;
    logic [2:0]         r_lat;
    logic [WDW-1:0]     r_wdog;

    logic [OPW-1:0]     w_opcode;
    logic [PCW-1:0]     w_target;
    logic [PCW-1:0]     w_pc_inc;
    logic               w_lat_done;
    logic               w_retire;
    logic               w_wdog_trip;
    logic               w_unused_ir;

    assign w_opcode    = r_ir[IW-1 -: OPW];
    assign w_target    = r_ir[PCW-1:0];
    assign w_pc_inc    = r_pc + PCW'(1);
    assign w_lat_done  = (r_lat == 3'(IRAM_LAT - 1));
    // Bits between opcode and target field are reserved and not decoded.
    assign w_unused_ir = ^r_ir;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_wdog_trip = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_lat_done) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_opcode == END_OP) begin
                    w_next = S_HALT;
                end else if (w_opcode == JMP_OP || w_opcode == JMPZ_OP) begin
                    w_retire = 1'b1;
                    w_next   = halt_req ? S_HALT : S_FETCH;
                end else begin
                    w_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                // A done pulse arriving together with go belongs to nothing
                // we issued, so it is deliberately not looked at here.
                w_next = S_EXEC;
            end
            S_EXEC: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (useq_done) begin
                    w_retire = 1'b1;
                    w_next   = halt_req ? S_HALT : S_FETCH;
                end else if (r_wdog == WDW'(WDOG - 1)) begin
                    w_wdog_trip = 1'b1;
                    w_next      = S_HALT;
                end
            end
            S_HALT: begin
                if (start) w_next = S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_useq_op  <= '0;
            r_count    <= '0;
            r_wdog_err <= 1'b0;
            r_lat      <= '0;
            r_wdog     <= '0;
        end else begin
            r_state <= w_next;

            if (w_retire) r_count <= r_count + 16'd1;
            if (w_wdog_trip) r_wdog_err <= 1'b1;

            case (r_state)
                S_FETCH: begin
                    r_lat <= '0;
                end
                S_WAIT: begin
                    r_lat <= r_lat + 3'd1;
                    if (w_lat_done) r_ir <= iram_rdata;
                end
                S_DECODE: begin
                    if (w_opcode == JMP_OP) begin
                        r_pc <= w_target;
                    end else if (w_opcode == JMPZ_OP) begin
                        r_pc <= z_flag ? w_target : w_pc_inc;
                    end else if (w_opcode != END_OP) begin
                        r_useq_op <= w_opcode;
                    end
                end
                S_DISPATCH: begin
                    r_wdog <= '0;
                end
                S_EXEC: begin
                    r_wdog <= r_wdog + WDW'(1);
                    if (useq_done) r_pc <= w_pc_inc;
                end
                S_HALT: begin
                    if (start) begin
                        r_pc       <= '0;
                        r_wdog_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from state so they are 0 straight out of reset)
    // ------------------------------------------------------------------
    assign iram_rd_en  = (r_state == S_FETCH);
    assign iram_addr   = r_pc;
    assign useq_go     = (r_state == S_DISPATCH);
    assign useq_op     = r_useq_op;
    assign pc          = r_pc;
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted      = (r_state == S_HALT);
    assign wdog_err    = r_wdog_err;
    assign instr_count = r_count;

endmodule
`default_nettype wire
